// File: rtl/dac_mux_pkg.sv
// Shared definitions for the DAC7611 / analog output mux scan controller.
//   DAC_BITS     : DAC code width
//   MUX_W        : width of the one-hot mux enable bus
//   scan_state_t : scan scheduler states
package dac_mux_pkg;
  localparam int DAC_BITS = 12;
  localparam int MUX_W    = 6;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    LOAD,
    SETTLE,
    NEXT,
    CLEAR
  } scan_state_t;
endpackage

// File: rtl/dac7611_shifter.sv
// Serialiser for the DAC7611 three-wire interface.
// A load pulse captures a 12-bit code; the word is then shifted out MSB
// first. Each bit spends HALF_PER clocks with dac_sclk low followed by
// HALF_PER clocks with dac_sclk high. dac_sdi only changes on the clock
// where dac_sclk falls, so it is stable across the DAC's rising-edge sample.
// Ports:
//   clk, reset         : clock, asynchronous active-high reset
//   load, code         : start a new word (code captured on this edge)
//   shift_done         : high during the final clock of the last high phase
//   dac_sclk, dac_sdi  : DAC pins (sclk idles high)
module dac7611_shifter
  import dac_mux_pkg::*;
#(
  parameter int HALF_PER = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [DAC_BITS-1:0] code,
  output logic                shift_done,
  output logic                dac_sclk,
  output logic                dac_sdi
);

  localparam int            HW     = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;
  localparam logic [HW-1:0] H_LAST = HW'(HALF_PER - 1);
  localparam logic [3:0]    B_LAST = 4'(DAC_BITS - 1);

  logic [DAC_BITS-1:0] shreg;
  logic [HW-1:0]       hcnt;
  logic [3:0]          bcnt;
  logic                active;
  logic                half_end;
  logic                fall;

  assign half_end   = (hcnt == H_LAST);
  // End of a high phase that still has bits left: drop sclk, present next bit.
  assign fall       = active & half_end & dac_sclk & (bcnt != B_LAST);
  assign shift_done = active & half_end & dac_sclk & (bcnt == B_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dac_sclk <= 1'b1;
      dac_sdi  <= 1'b0;
      hcnt     <= '0;
      bcnt     <= '0;
      active   <= 1'b0;
    end else if (load) begin
      // First low phase starts immediately with the MSB already on sdi.
      dac_sclk <= 1'b0;
      dac_sdi  <= code[DAC_BITS-1];
      hcnt     <= '0;
      bcnt     <= '0;
      active   <= 1'b1;
    end else if (active) begin
      if (!half_end) begin
        hcnt <= hcnt + HW'(1);
      end else begin
        hcnt <= '0;
        if (!dac_sclk) begin
          dac_sclk <= 1'b1;
        end else if (fall) begin
          dac_sclk <= 1'b0;
          bcnt     <= bcnt + 4'd1;
          dac_sdi  <= shreg[DAC_BITS-2];
        end else begin
          // Last bit done: sclk stays high, sdi holds the last bit.
          active <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      shreg <= code;
    end else if (fall) begin
      shreg <= {shreg[DAC_BITS-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/dac_mux_scan_ctrl.sv
// Scan scheduler for the DAC7611 serial DAC feeding the analog output mux.
// Holds one 12-bit code per mux channel and walks channels 0..NUM_CH-1:
// shift the code into the DAC, pulse LD, then close that channel's mux
// switch for SETTLE_CYC clocks. A pending clear request is serviced only
// in IDLE or between channels (NEXT), never in the middle of a shift.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   start, cont       : frame start pulse / continuous-scan level
//   wr_en, wr_ch,
//   wr_code           : code register write (wr_ch >= NUM_CH ignored)
//   clr_req           : request a DAC clear pulse
//   busy, done,
//   cur_ch            : frame status
//   mux_sel           : one-hot mux switch enables, 0 = all open
//   dac_sclk, dac_sdi,
//   dac_ld_n,
//   dac_clr_n         : DAC7611 pins
module dac_mux_scan_ctrl
  import dac_mux_pkg::*;
#(
  parameter int NUM_CH     = 6,
  parameter int HALF_PER   = 2,
  parameter int LD_CYC     = 2,
  parameter int SETTLE_CYC = 128,
  parameter int CLR_CYC    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                cont,
  input  logic                wr_en,
  input  logic [2:0]          wr_ch,
  input  logic [DAC_BITS-1:0] wr_code,
  input  logic                clr_req,
  output logic                busy,
  output logic                done,
  output logic [2:0]          cur_ch,
  output logic [MUX_W-1:0]    mux_sel,
  output logic                dac_sclk,
  output logic                dac_sdi,
  output logic                dac_ld_n,
  output logic                dac_clr_n
);

  localparam logic [2:0]  LAST_CH    = 3'(NUM_CH - 1);
  localparam logic [15:0] LD_END     = 16'(LD_CYC);
  localparam logic [15:0] SETTLE_END = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] CLR_END    = 16'(CLR_CYC - 1);

  scan_state_t         state, state_n;
  logic [2:0]          ch, ch_n;
  logic [15:0]         tmr;
  logic                clr_pend;
  logic                clr_from_idle;
  logic [DAC_BITS-1:0] codes [MUX_W];
  logic [DAC_BITS-1:0] load_code;
  logic                load;
  logic                adv;
  logic                end_frame;
  logic                shift_done;
  logic                entering_clear;

  assign entering_clear = (state_n == CLEAR) && (state != CLEAR);

  // A write in the same cycle as the load is forwarded, so it lands first.
  assign load_code = (wr_en && (wr_ch == ch_n)) ? wr_code : codes[ch_n];

  dac7611_shifter #(
    .HALF_PER (HALF_PER)
  ) u_shifter (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .code       (load_code),
    .shift_done (shift_done),
    .dac_sclk   (dac_sclk),
    .dac_sdi    (dac_sdi)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MUX_W; i++) codes[i] <= '0;
    end else if (wr_en && (wr_ch <= LAST_CH)) begin
      codes[wr_ch] <= wr_code;
    end
  end

  // State register, channel counter, shared LD/SETTLE/CLR timer, clear flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      ch            <= '0;
      tmr           <= '0;
      clr_pend      <= 1'b0;
      clr_from_idle <= 1'b0;
    end else begin
      state <= state_n;
      ch    <= ch_n;
      tmr   <= (state_n != state) ? 16'd0 : tmr + 16'd1;
      if (clr_req) begin
        clr_pend <= 1'b1;
      end else if (entering_clear) begin
        clr_pend <= 1'b0;
      end
      if (entering_clear) begin
        clr_from_idle <= (state == IDLE);
      end
    end
  end

  // Next state. adv is the shared "channel finished" decision taken from
  // NEXT, or from the end of a clear inserted between channels.
  always_comb begin
    state_n   = state;
    ch_n      = ch;
    load      = 1'b0;
    adv       = 1'b0;
    end_frame = 1'b0;
    unique case (state)
      IDLE: begin
        if (clr_pend) begin
          state_n = CLEAR;
        end else if (start) begin
          state_n = SHIFT;
          ch_n    = '0;
          load    = 1'b1;
        end
      end
      SHIFT:  if (shift_done) state_n = LOAD;
      LOAD:   if (tmr == LD_END) state_n = SETTLE;
      SETTLE: if (tmr == SETTLE_END) state_n = NEXT;
      NEXT: begin
        if (clr_pend) state_n = CLEAR;
        else          adv     = 1'b1;
      end
      CLEAR: begin
        if (tmr == CLR_END) begin
          if (clr_from_idle) state_n = IDLE;
          else               adv     = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (adv) begin
      if (ch != LAST_CH) begin
        ch_n    = ch + 3'd1;
        state_n = SHIFT;
        load    = 1'b1;
      end else begin
        end_frame = 1'b1;
        ch_n      = '0;
        if (cont) begin
          state_n = SHIFT;
          load    = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
    end
  end

  // Outputs. LOAD spends its first clock with ld_n high (sclk high setup).
  always_comb begin
    busy      = (state != IDLE) && !((state == CLEAR) && clr_from_idle);
    done      = end_frame;
    cur_ch    = ch;
    mux_sel   = '0;
    if (state == SETTLE) mux_sel = MUX_W'(1) << ch;
    dac_ld_n  = !((state == LOAD) && (tmr != 16'd0));
    dac_clr_n = (state != CLEAR);
  end

endmodule

// File: tb/tb_dac_mux_scan_ctrl.sv
module tb_dac_mux_scan_ctrl;

  localparam int HP  = 2;
  localparam int LDC = 2;
  localparam int SET = 128;
  localparam int CLR = 2;

  typedef struct packed {
    logic [2:0]  ch;
    logic [11:0] code;
    logic [5:0]  mux;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, start, cont, wr_en, clr_req;
  logic [2:0]  wr_ch;
  logic [11:0] wr_code;
  logic        busy, done, dac_sclk, dac_sdi, dac_ld_n, dac_clr_n;
  logic [2:0]  cur_ch;
  logic [5:0]  mux_sel;

  dac_mux_scan_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .cont      (cont),
    .wr_en     (wr_en),
    .wr_ch     (wr_ch),
    .wr_code   (wr_code),
    .clr_req   (clr_req),
    .busy      (busy),
    .done      (done),
    .cur_ch    (cur_ch),
    .mux_sel   (mux_sel),
    .dac_sclk  (dac_sclk),
    .dac_sdi   (dac_sdi),
    .dac_ld_n  (dac_ld_n),
    .dac_clr_n (dac_clr_n)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          viol    = 0;
  int          s0;
  logic [11:0] model [6];
  exp_t        sbq [$];
  exp_t        tbl [6];
  int          done_cyc [$];
  int          clr_start [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: decodes the serial stream on sclk rising edges, pops the
  // scoreboard on each LD pulse and tracks pulse lengths and done/clear times.
  logic        prev_sclk, prev_ld, prev_clr, prev_sdi;
  logic [5:0]  prev_mux, last_mux;
  logic [11:0] sh_word;
  int          sh_bits, ld_len, mux_len, clr_len, low_len, last_rise;
  exp_t        e;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      prev_sclk = 1'b1; prev_ld = 1'b1; prev_clr = 1'b1; prev_sdi = 1'b0;
      prev_mux = '0; last_mux = '0; sh_word = '0;
      sh_bits = 0; ld_len = 0; mux_len = 0; clr_len = 0; low_len = 0; last_rise = 0;
    end else begin
      if (!dac_sclk) low_len++;
      if (!prev_sclk && dac_sclk) begin
        sh_word   = {sh_word[10:0], dac_sdi};
        sh_bits++;
        last_rise = cyc;
        if (low_len != HP) viol++;
        low_len = 0;
      end
      if ((dac_sdi !== prev_sdi) && !(prev_sclk && !dac_sclk)) viol++;
      if (prev_ld && !dac_ld_n) begin
        check("ld_delay", cyc - last_rise, HP + 1);
        check("sclk_bits", sh_bits, 12);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          check($sformatf("word_ch%0d", e.ch), sh_word, e.code);
          check("ld_cur_ch", cur_ch, e.ch);
          last_mux = e.mux;
        end else begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h, expected no word", sh_word);
        end
        sh_bits = 0;
      end
      if (!dac_ld_n) ld_len++;
      if (!prev_ld && dac_ld_n) begin
        check("ld_len", ld_len, LDC);
        ld_len = 0;
      end
      if (mux_sel != '0) begin
        if (!dac_ld_n || !dac_sclk || !dac_clr_n) viol++;
        if (prev_mux == '0) check("mux_sel", mux_sel, last_mux);
        mux_len++;
      end else if (prev_mux != '0) begin
        check("settle_len", mux_len, SET);
        mux_len = 0;
      end
      if (done) done_cyc.push_back(cyc);
      if (!dac_clr_n) begin
        if (prev_clr) clr_start.push_back(cyc);
        clr_len++;
      end else if (!prev_clr) begin
        check("clr_len", clr_len, CLR);
        clr_len = 0;
      end
      prev_sclk = dac_sclk; prev_ld = dac_ld_n; prev_clr = dac_clr_n;
      prev_sdi  = dac_sdi;  prev_mux = mux_sel;
    end
  end

  task automatic wr(input logic [2:0] c, input logic [11:0] v);
    wr_en = 1'b1; wr_ch = c; wr_code = v;
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (c < 3'd6) model[c] = v;
  endtask

  task automatic push_frame();
    for (int c = 0; c < 6; c++) sbq.push_back({3'(c), model[c], 6'(1 << c)});
  endtask

  task automatic go();
    start = 1'b1;
    @(posedge clk);
    s0 = cyc;
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int i;
    i = 0;
    while (busy && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    check(nm, busy, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_cur_ch"}, cur_ch, 0);
    check({tag, "_mux_sel"}, mux_sel, 0);
    check({tag, "_sclk"}, dac_sclk, 1);
    check({tag, "_sdi"}, dac_sdi, 0);
    check({tag, "_ld_n"}, dac_ld_n, 1);
    check({tag, "_clr_n"}, dac_clr_n, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bsum;
    tbl[0] = {3'd0, 12'h000, 6'b000001};
    tbl[1] = {3'd1, 12'hFFF, 6'b000010};
    tbl[2] = {3'd2, 12'h800, 6'b000100};
    tbl[3] = {3'd3, 12'h001, 6'b001000};
    tbl[4] = {3'd4, 12'hABC, 6'b010000};
    tbl[5] = {3'd5, 12'h7FF, 6'b100000};
    for (int c = 0; c < 6; c++) model[c] = 12'h000;
    reset = 1'b1; start = 1'b0; cont = 1'b0; wr_en = 1'b0;
    wr_ch = '0; wr_code = '0; clr_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: single code on ch0, one frame
    wr(3'd0, 12'h555);
    push_frame();
    go();
    wait_idle(1200, "t1_idle");
    check("t1_done_count", done_cyc.size(), 1);
    check("t1_sb_empty", sbq.size(), 0);
    check("t1_viol", viol, 0);
    done_cyc.delete();

    // 2: table of codes; ch0 written in the same cycle as start
    for (int i = 1; i < 6; i++) wr(tbl[i].ch, tbl[i].code);
    model[0] = tbl[0].code;
    for (int i = 0; i < 6; i++) sbq.push_back(tbl[i]);
    wr_en = 1'b1; wr_ch = tbl[0].ch; wr_code = tbl[0].code;
    go();
    wr_en = 1'b0;
    repeat (1079) @(posedge clk);
    #1;
    check("t2_done_at_1080", done, 1);
    check("t2_busy_at_done", busy, 1);
    @(posedge clk); #1;
    check("t2_busy_drop", busy, 0);
    check("t2_done_off", done, 0);
    check("t2_done_count", done_cyc.size(), 1);
    if (done_cyc.size() > 0) check("t2_done_cyc", done_cyc[0] - s0, 1080);
    check("t2_sb_empty", sbq.size(), 0);
    check("t2_viol", viol, 0);
    done_cyc.delete();

    // 3: continuous scan, start while busy, cont dropped in frame 2
    cont = 1'b1;
    push_frame();
    push_frame();
    go();
    repeat (500) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (1000) @(posedge clk);
    #1 cont = 1'b0;
    wait_idle(1200, "t3_idle");
    check("t3_done_count", done_cyc.size(), 2);
    if (done_cyc.size() > 1) begin
      check("t3_done_first", done_cyc[0] - s0, 1080);
      check("t3_done_spacing", done_cyc[1] - done_cyc[0], 1080);
    end
    check("t3_sb_empty", sbq.size(), 0);
    check("t3_viol", viol, 0);
    done_cyc.delete();

    // 4: clear requested during ch2 shift, then clear from IDLE
    push_frame();
    go();
    repeat (369) @(posedge clk);
    #1;
    check("t4_in_ch2", cur_ch, 2);
    check("t4_clr_n_shift", dac_clr_n, 1);
    clr_req = 1'b1;
    @(posedge clk); #1 clr_req = 1'b0;
    wait_idle(1300, "t4_idle");
    check("t4_clr_count", clr_start.size(), 1);
    if (clr_start.size() > 0) check("t4_clr_start", clr_start[0] - s0, 3 * 180 + 1);
    check("t4_done_count", done_cyc.size(), 1);
    if (done_cyc.size() > 0) check("t4_done_cyc", done_cyc[0] - s0, 1080 + CLR);
    check("t4_sb_empty", sbq.size(), 0);
    clr_req = 1'b1;
    @(posedge clk); #1 clr_req = 1'b0;
    bsum = 0;
    repeat (6) begin
      @(posedge clk); #1;
      bsum += int'(busy);
    end
    check("t4_idle_clr_busy", bsum, 0);
    check("t4_idle_clr_count", clr_start.size(), 2);
    check("t4_viol", viol, 0);
    done_cyc.delete();
    clr_start.delete();

    // 5: asynchronous reset mid-shift; codes lost
    wr(3'd3, 12'h9A5);
    go();
    repeat (10) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check_reset_outputs("t5_async");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    sbq.delete();
    done_cyc.delete();
    for (int c = 0; c < 6; c++) model[c] = 12'h000;
    push_frame();
    go();
    wait_idle(1200, "t5_idle");
    check("t5_sb_empty", sbq.size(), 0);
    check("t5_done_count", done_cyc.size(), 1);
    done_cyc.delete();

    // 6: out-of-range write ignored; write to ch1 during its shift is deferred
    for (int c = 0; c < 6; c++) wr(3'(c), 12'h100 + 12'(c * 17));
    wr(3'd7, 12'h3C3);
    push_frame();
    go();
    repeat (189) @(posedge clk);
    #1;
    check("t6_in_ch1", cur_ch, 1);
    wr_en = 1'b1; wr_ch = 3'd1; wr_code = 12'hE1E;
    @(posedge clk); #1 wr_en = 1'b0;
    wait_idle(1200, "t6_idle_a");
    model[1] = 12'hE1E;
    push_frame();
    go();
    wait_idle(1200, "t6_idle_b");
    check("t6_sb_empty", sbq.size(), 0);
    check("t6_viol", viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
